// File: rtl/exec_pkg.sv
// Shared definitions for the vector execute stage.
//   alu_op_t  : 3-bit ALU operation encoding
//   cond_t    : 4-bit condition codes
//   FLAG_*    : bit positions of N, Z, C, V inside a 4-bit NZCV vector
//   cond_pass : evaluates a condition code against an NZCV vector
package exec_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_ORR = 3'b011,
        ALU_LSL = 3'b100,
        ALU_LSR = 3'b101,
        ALU_MUL = 3'b110,
        ALU_MOV = 3'b111
    } alu_op_t;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_t;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    function automatic logic cond_pass(input cond_t cond, input logic [3:0] flags);
        logic n, z, c, v, pass;
        n = flags[FLAG_N];
        z = flags[FLAG_Z];
        c = flags[FLAG_C];
        v = flags[FLAG_V];
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            default: pass = 1'b1;
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/vec_alu_lane.sv
// Combinational single-lane ALU.
//   a_i, b_i   : operands
//   op_i       : ALU operation (alu_op_t encoding)
//   result_o   : XLEN-bit result (MUL keeps the low XLEN bits)
//   carry_o    : carry out of the adder (A + ~B + 1 for SUB)
//   overflow_o : signed overflow of the adder
module vec_alu_lane
    import exec_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [2:0]      op_i,
    output logic [XLEN-1:0] result_o,
    output logic            carry_o,
    output logic            overflow_o
);

    localparam int unsigned SHW = $clog2(XLEN);

    alu_op_t         op;
    logic [XLEN-1:0] b_add;
    logic [XLEN:0]   sum;

    always_comb begin
        op    = alu_op_t'(op_i);
        b_add = (op == ALU_SUB) ? ~b_i : b_i;
        sum   = {1'b0, a_i} + {1'b0, b_add} + {{XLEN{1'b0}}, (op == ALU_SUB)};

        carry_o    = sum[XLEN];
        // Overflow when both adder inputs share a sign that the sum does not.
        overflow_o = (a_i[XLEN-1] == b_add[XLEN-1]) && (sum[XLEN-1] != a_i[XLEN-1]);

        case (op)
            ALU_ADD, ALU_SUB: result_o = sum[XLEN-1:0];
            ALU_AND:          result_o = a_i & b_i;
            ALU_ORR:          result_o = a_i | b_i;
            ALU_LSL:          result_o = a_i << b_i[SHW-1:0];
            ALU_LSR:          result_o = a_i >> b_i[SHW-1:0];
            ALU_MUL:          result_o = a_i * b_i;
            ALU_MOV:          result_o = b_i;
            default:          result_o = '0;
        endcase
    end

endmodule

// File: rtl/vec_exec_stage.sv
// Execute stage with a time-multiplexed vector ALU.
//   CLK, RST            : clock, synchronous active-high reset
//   ValidE, FlushE      : slot holds an instruction / abort current instruction
//   RD1E, RD2E, ExtImmE : lane operands and immediate
//   CondE, FlagsE       : condition code and the NZCV it is tested against
//   *E controls         : decoded controls, qualified by the condition at completion
//   v_s_e               : 1 = vector op over all lanes, 0 = scalar op on lane 0
//   StallE              : holds upstream while a vector op walks its lane groups
//   *M outputs          : execute-to-memory register contents
//   FlagsOut            : architectural NZCV
module vec_exec_stage
    import exec_pkg::*;
#(
    parameter int unsigned LANES           = 16,
    parameter int unsigned XLEN            = 32,
    parameter int unsigned LANES_PER_CYCLE = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        ValidE,
    input  logic                        FlushE,
    input  logic [LANES-1:0][XLEN-1:0]  RD1E,
    input  logic [LANES-1:0][XLEN-1:0]  RD2E,
    input  logic [XLEN-1:0]             ExtImmE,
    input  logic [3:0]                  CondE,
    input  logic [3:0]                  FlagsE,
    input  logic                        PCSrcE,
    input  logic                        RegWriteE,
    input  logic                        MemtoRegE,
    input  logic                        MemWriteE,
    input  logic                        BranchE,
    input  logic                        ALUSrcE,
    input  logic [2:0]                  ALUControlE,
    input  logic [1:0]                  FlagWriteE,
    input  logic [3:0]                  WA3E,
    input  logic                        v_s_e,
    output logic                        StallE,
    output logic [LANES-1:0][XLEN-1:0]  ALUResultM,
    output logic [LANES-1:0][XLEN-1:0]  WriteDataM,
    output logic                        RegWriteM,
    output logic                        MemWriteM,
    output logic                        MemtoRegM,
    output logic                        PCSrcM,
    output logic [3:0]                  WA3M,
    output logic                        v_s_m,
    output logic                        ValidM,
    output logic [3:0]                  FlagsOut
);

    localparam int unsigned LPC   = LANES_PER_CYCLE;
    localparam int unsigned NGRP  = LANES / LPC;
    localparam int unsigned GRPW  = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int unsigned LIDXW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [GRPW-1:0] LAST_GRP = GRPW'(NGRP - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t                     state_q, state_d;
    logic [GRPW-1:0]            grp_q, grp_d;
    logic [LANES-1:0][XLEN-1:0] buf_q, buf_d;
    logic                       c0_q, c0_d;
    logic                       v0_q, v0_d;

    logic [LANES-1:0][XLEN-1:0] res_q, res_d;
    logic [LANES-1:0][XLEN-1:0] wdata_q, wdata_d;
    logic                       regw_q, regw_d;
    logic                       memw_q, memw_d;
    logic                       mem2r_q, mem2r_d;
    logic                       pcsrc_q, pcsrc_d;
    logic [3:0]                 wa3_q, wa3_d;
    logic                       vs_q, vs_d;
    logic                       valid_q, valid_d;
    logic [3:0]                 flags_q, flags_d;

    logic [GRPW-1:0]  grp_cur;
    logic [LIDXW-1:0] lidx  [LPC];
    logic [XLEN-1:0]  src_a [LPC];
    logic [XLEN-1:0]  src_b [LPC];
    logic [XLEN-1:0]  lres  [LPC];
    logic [LPC-1:0]   lcy;
    logic [LPC-1:0]   lov;
    logic             unused_lane_flags;

    logic                       stall;
    logic                       done;
    logic                       cond_ok;
    logic                       c_use;
    logic                       v_use;
    logic [LANES-1:0][XLEN-1:0] full_res;
    alu_op_t                    op;

    // Scalar ops always use the lane-0 group.
    assign grp_cur = v_s_e ? grp_q : '0;
    assign op      = alu_op_t'(ALUControlE);

    always_comb begin
        for (int unsigned k = 0; k < LPC; k++) begin
            lidx[k]  = LIDXW'(32'(grp_cur) * LPC + k);
            src_a[k] = RD1E[lidx[k]];
            src_b[k] = ALUSrcE ? ExtImmE : RD2E[lidx[k]];
        end
    end

    for (genvar k = 0; k < LPC; k++) begin : g_lane
        vec_alu_lane #(
            .XLEN(XLEN)
        ) u_lane (
            .a_i        (src_a[k]),
            .b_i        (src_b[k]),
            .op_i       (ALUControlE),
            .result_o   (lres[k]),
            .carry_o    (lcy[k]),
            .overflow_o (lov[k])
        );
    end

    // Only lane 0 feeds the flags; the other lanes' carry/overflow are dropped.
    assign unused_lane_flags = ^{lcy, lov};

    always_comb begin
        state_d  = state_q;
        grp_d    = grp_q;
        buf_d    = buf_q;
        c0_d     = c0_q;
        v0_d     = v0_q;
        res_d    = res_q;
        wdata_d  = wdata_q;
        regw_d   = 1'b0;
        memw_d   = 1'b0;
        mem2r_d  = mem2r_q;
        pcsrc_d  = 1'b0;
        wa3_d    = wa3_q;
        vs_d     = vs_q;
        valid_d  = 1'b0;
        flags_d  = flags_q;
        stall    = 1'b0;
        done     = 1'b0;
        full_res = '0;
        cond_ok  = cond_pass(cond_t'(CondE), FlagsE);

        if (FlushE || !ValidE) begin
            grp_d = '0;
        end else if (!v_s_e) begin
            done        = 1'b1;
            full_res[0] = lres[0];
            grp_d       = '0;
        end else begin
            for (int unsigned k = 0; k < LPC; k++) begin
                buf_d[lidx[k]] = lres[k];
            end
            // Lane 0 is computed in the first group; keep its adder flags
            // for the completion cycle, which may be several cycles later.
            if (state_q == S_IDLE) begin
                c0_d = lcy[0];
                v0_d = lov[0];
            end
            if (grp_q == LAST_GRP) begin
                done     = 1'b1;
                full_res = buf_d;
                grp_d    = '0;
            end else begin
                stall = 1'b1;
                grp_d = grp_q + 1'b1;
            end
        end

        c_use = (v_s_e && state_q == S_RUN) ? c0_q : lcy[0];
        v_use = (v_s_e && state_q == S_RUN) ? v0_q : lov[0];

        if (done) begin
            res_d   = full_res;
            wdata_d = RD2E;
            regw_d  = RegWriteE & cond_ok;
            memw_d  = MemWriteE & cond_ok;
            pcsrc_d = (PCSrcE | BranchE) & cond_ok;
            mem2r_d = MemtoRegE;
            wa3_d   = WA3E;
            vs_d    = v_s_e;
            valid_d = 1'b1;
            if (cond_ok) begin
                if (FlagWriteE[1]) begin
                    flags_d[FLAG_N] = full_res[0][XLEN-1];
                    flags_d[FLAG_Z] = (full_res[0] == '0);
                end
                if (FlagWriteE[0] && (op == ALU_ADD || op == ALU_SUB)) begin
                    flags_d[FLAG_C] = c_use;
                    flags_d[FLAG_V] = v_use;
                end
            end
        end

        state_d = (grp_d == '0) ? S_IDLE : S_RUN;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            grp_q   <= '0;
            buf_q   <= '0;
            c0_q    <= 1'b0;
            v0_q    <= 1'b0;
            res_q   <= '0;
            wdata_q <= '0;
            regw_q  <= 1'b0;
            memw_q  <= 1'b0;
            mem2r_q <= 1'b0;
            pcsrc_q <= 1'b0;
            wa3_q   <= '0;
            vs_q    <= 1'b0;
            valid_q <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            buf_q   <= buf_d;
            c0_q    <= c0_d;
            v0_q    <= v0_d;
            res_q   <= res_d;
            wdata_q <= wdata_d;
            regw_q  <= regw_d;
            memw_q  <= memw_d;
            mem2r_q <= mem2r_d;
            pcsrc_q <= pcsrc_d;
            wa3_q   <= wa3_d;
            vs_q    <= vs_d;
            valid_q <= valid_d;
            flags_q <= flags_d;
        end
    end

    assign StallE     = stall & ~RST;
    assign ALUResultM = res_q;
    assign WriteDataM = wdata_q;
    assign RegWriteM  = regw_q;
    assign MemWriteM  = memw_q;
    assign MemtoRegM  = mem2r_q;
    assign PCSrcM     = pcsrc_q;
    assign WA3M       = wa3_q;
    assign v_s_m      = vs_q;
    assign ValidM     = valid_q;
    assign FlagsOut   = flags_q;

endmodule
